// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner: channel FSM states,
// Basys3 button index constants and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_LOW,
    BTN_WAIT_HIGH,
    BTN_HIGH,
    BTN_WAIT_LOW
  } btn_state_t;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int BTN_R = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter width serves both the debounce and the hold counters.
  function automatic int cnt_width(input int d, input int rd, input int rp);
    return $clog2(max3(d, rd, rp));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and registered edge pulses.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            s;
  btn_state_t      state;
  logic [CW-1:0]   cnt;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] hold;
  logic          repeating;
  logic [CW-1:0] hold_last;

  assign hold_last = repeating ? PERIOD_LAST : DELAY_LAST;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b0;
      s             <= 1'b0;
      state         <= BTN_LOW;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      hold          <= '0;
      repeating     <= 1'b0;
`endif
    end else begin
      sync1         <= raw;
      s             <= sync1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        BTN_LOW: begin
          if (s) begin
            state <= BTN_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        BTN_WAIT_HIGH: begin
          if (!s) begin
            state <= BTN_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= BTN_HIGH;
            level <= 1'b1;
            press <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BTN_HIGH: begin
          if (!s) begin
            state <= BTN_WAIT_LOW;
            cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            hold      <= '0;
            repeating <= 1'b0;
          end else if (hold == hold_last) begin
            // First repeat after the long delay, later ones at the shorter period.
            press     <= 1'b1;
            hold      <= '0;
            repeating <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
`endif
          end
        end
        BTN_WAIT_LOW: begin
          if (s) begin
            state <= BTN_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= BTN_LOW;
            level         <= 1'b0;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BTN_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Basys3 push-button front end: one independent debounce channel per button.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_conditioner #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .raw          (btn_in[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length
// reference model; predicted pulses are queued and matched by a monitor.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int W  = 32 + 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int unsigned  cyc = 0;
  logic [N-1:0] model_level = '0;

  // Model state: raw-input delay line, current run of equal observed samples,
  // committed level and held-edge count since entering the high level.
  int p1[N], p2[N], run_val[N], run_len[N], lvl[N], hold[N];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // ---------------- reference model ----------------
  always @(posedge clk or posedge rst) begin
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    int obs;
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        p1[ch] = 0; p2[ch] = 0; run_val[ch] = 0; run_len[ch] = 0;
        lvl[ch] = 0; hold[ch] = 0;
      end
      model_level = '0;
      exp_q.delete();
    end else begin
      cyc++;
      pr = '0;
      rl = '0;
      for (int ch = 0; ch < N; ch++) begin
        obs = p2[ch];
        p2[ch] = p1[ch];
        p1[ch] = int'(btn_in[ch]);
        if (obs == run_val[ch] && run_len[ch] < 1000000) run_len[ch]++;
        else if (obs != run_val[ch]) begin
          run_val[ch] = obs;
          run_len[ch] = 1;
        end
        if (run_val[ch] != lvl[ch] && run_len[ch] == D + 1) begin
          lvl[ch] = run_val[ch];
          if (lvl[ch] == 1) pr[ch] = 1'b1;
          else rl[ch] = 1'b1;
          hold[ch] = 0;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (lvl[ch] == 1 && obs == 1) begin
          if (run_len[ch] == 1) hold[ch] = 0;
          else begin
            hold[ch]++;
            if (hold[ch] == RD || (hold[ch] > RD && (hold[ch] - RD) % RP == 0))
              pr[ch] = 1'b1;
          end
        end
`endif
        model_level[ch] = (lvl[ch] == 1);
      end
      if ((pr | rl) != '0) exp_q.push_back({cyc, pr, rl});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs got %b want 0", {btn_level, btn_press, btn_release});
      end
    end else begin
      vectors++;
      if (btn_level !== model_level) begin
        miscompares++;
        $display("FAIL level cyc %0d got %b want %b", cyc, btn_level, model_level);
      end
      while (exp_q.size() > 0 && exp_q[0][W-1:2*N] < cyc) begin
        mon_e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_pulse cyc %0d got none want press %b release %b",
                 mon_e[W-1:2*N], mon_e[2*N-1:N], mon_e[N-1:0]);
      end
      if (exp_q.size() > 0 && exp_q[0][W-1:2*N] == cyc) begin
        mon_e = exp_q.pop_front();
        vectors++;
        if ({btn_press, btn_release} !== mon_e[2*N-1:0]) begin
          miscompares++;
          $display("FAIL pulse cyc %0d got press %b release %b want press %b release %b",
                   cyc, btn_press, btn_release, mon_e[2*N-1:N], mon_e[N-1:0]);
        end
      end else if ((btn_press | btn_release) !== '0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse cyc %0d got press %b release %b want none",
                 cyc, btn_press, btn_release);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_count(input int n, input int ch, output int np, output int nr);
    np = 0;
    nr = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      np += int'(btn_press[ch]);
      nr += int'(btn_release[ch]);
    end
  endtask

  // Edges from now until the first press on channel ch (0 if none within limit).
  task automatic edges_to_press(input int ch, input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (btn_press[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, np, nr;
    logic [N-1:0] seen;

    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);

    // Clean press: level and press rise together 2 + D + 1 edges after the input.
    btn_in[BTN_C] = 1'b1;
    edges_to_press(BTN_C, 20, n);
    check_int("press_latency", n, 2 + D + 1);
    check_int("level_with_press", int'(btn_level[BTN_C]), 1);
    tick_count(12, BTN_C, np, nr);
    check_int("clean_extra_press", np, 0);
    check_int("clean_no_release", nr, 0);
    @(negedge clk);
    btn_in[BTN_C] = 1'b0;
    wait_neg(12);

    // Glitch shorter than the debounce window is rejected.
    btn_in[BTN_L] = 1'b1;
    wait_neg(3);
    btn_in[BTN_L] = 1'b0;
    tick_count(15, BTN_L, np, nr);
    check_int("glitch_press", np, 0);
    check_int("glitch_release", nr, 0);
    @(negedge clk);

    // Bounce then settle: one press, then one release.
    btn_in[BTN_D] = 1'b1; @(negedge clk);
    btn_in[BTN_D] = 1'b0; @(negedge clk);
    btn_in[BTN_D] = 1'b1; @(negedge clk);
    btn_in[BTN_D] = 1'b0; @(negedge clk);
    btn_in[BTN_D] = 1'b1;
    tick_count(15, BTN_D, np, nr);
    check_int("bounce_press_count", np, 1);
    @(negedge clk);
    btn_in[BTN_D] = 1'b0;
    tick_count(15, BTN_D, np, nr);
    check_int("bounce_release_count", nr, 1);
    @(negedge clk);

    // Async reset mid-debounce, with another channel already committed high.
    btn_in[BTN_R] = 1'b1;
    wait_neg(12);
    check_int("pre_reset_level_r", int'(btn_level[BTN_R]), 1);
    btn_in[BTN_C] = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_int("async_reset_outputs", int'({btn_level, btn_press, btn_release}), 0);
    @(negedge clk);
    rst = 1'b0;
    edges_to_press(BTN_C, 20, n);
    check_int("press_after_reset", n, 2 + D + 1);
    @(negedge clk);
    btn_in = '0;
    wait_neg(12);

    // Simultaneous channels.
    btn_in = 5'b01001;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (btn_press != '0) begin
        seen = btn_press;
        break;
      end
    end
    check_int("simultaneous_press", int'(seen), int'(5'b01001));
    @(negedge clk);
    btn_in[BTN_D] = 1'b0;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (btn_release != '0) begin
        seen = btn_release;
        break;
      end
    end
    check_int("single_release", int'(seen), int'(5'b01000));
    @(negedge clk);
    btn_in = '0;
    wait_neg(12);

    // Long hold: auto-repeat presses when enabled, otherwise a single press.
    btn_in[BTN_C] = 1'b1;
    tick_count(2 + D + 1 + 28, BTN_C, np, nr);
`ifdef BUTTON_AUTOREPEAT_EN
    check_int("hold_press_count", np, 8);
`else
    check_int("hold_press_count", np, 1);
`endif
    @(negedge clk);
    btn_in[BTN_C] = 1'b0;
    tick_count(20, BTN_C, np, nr);
    check_int("after_hold_press", np, 0);
    check_int("after_hold_release", nr, 1);
    @(negedge clk);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) btn_in[b] = ~btn_in[b];
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    btn_in = '0;
    wait_neg(30);
    check_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
